// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the data cache
// (port 0) and the instruction refill engine (port 1), with a timeout watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,
    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              err_o,
    output logic [1:0]        grant_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                mem_enable_d = 1'b0;
                // Port 0 wins when alone, or on a tie if port 1 was served last.
                if (req0_enable_i && (!req1_enable_i || last_grant_q)) begin
                    state_d      = BUSY0;
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                    mem_enable_d = 1'b1;
                    mem_write_d  = req0_write_i;
                    mem_addr_d   = req0_addr_i;
                    mem_data_d   = req0_data_i;
                end else if (req1_enable_i) begin
                    state_d      = BUSY1;
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    mem_enable_d = 1'b1;
                    mem_write_d  = req1_write_i;
                    mem_addr_d   = req1_addr_i;
                    mem_data_d   = req1_data_i;
                end
            end
            BUSY0, BUSY1: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    mem_enable_d = 1'b0;
                end else begin
                    cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
                    // Abort on the edge where the count of unacknowledged cycles hits TIMEOUT.
                    if (cnt_q + CNT_W'(1) >= CNT_W'(TIMEOUT)) begin
                        state_d      = IDLE;
                        mem_enable_d = 1'b0;
                        err_d        = 1'b1;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
            end
        endcase
    end

    assign req0_ack_o   = (state_q == BUSY0) && mem_ack_i;
    assign req1_ack_o   = (state_q == BUSY1) && mem_ack_i;
    assign req0_data_o  = req0_ack_o ? mem_data_i : '0;
    assign req1_data_o  = req1_ack_o ? mem_data_i : '0;
    assign grant_o      = {state_q == BUSY1, state_q == BUSY0};
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rst_to_n;
    logic          r0_en, r0_wr, r1_en, r1_wr, to_en;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_data, r1_data;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          ack0, ack1, mem_en, mem_wr, err;
    logic [DW-1:0] rd0, rd1, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;

    logic          to_ack0, to_ack1, to_mem_en, to_mem_wr, to_err;
    logic [DW-1:0] to_rd0, to_rd1, to_mem_wdata;
    logic [AW-1:0] to_mem_addr;
    logic [1:0]    to_grant;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(1023)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req0_enable_i(r0_en), .req0_write_i(r0_wr), .req0_addr_i(r0_addr), .req0_data_i(r0_data),
        .req0_ack_o(ack0), .req0_data_o(rd0),
        .req1_enable_i(r1_en), .req1_write_i(r1_wr), .req1_addr_i(r1_addr), .req1_data_i(r1_data),
        .req1_ack_o(ack1), .req1_data_o(rd1),
        .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_data_i(mem_rdata), .err_o(err), .grant_o(grant)
    );

    // Second instance with a short watchdog and a memory that never answers.
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut_to (
        .clk_i(clk), .rst_i(rst_to_n),
        .req0_enable_i(to_en), .req0_write_i(r0_wr), .req0_addr_i(r0_addr), .req0_data_i(r0_data),
        .req0_ack_o(to_ack0), .req0_data_o(to_rd0),
        .req1_enable_i(1'b0), .req1_write_i(r1_wr), .req1_addr_i(r1_addr), .req1_data_i(r1_data),
        .req1_ack_o(to_ack1), .req1_data_o(to_rd1),
        .mem_enable_o(to_mem_en), .mem_write_o(to_mem_wr), .mem_addr_o(to_mem_addr),
        .mem_data_o(to_mem_wdata), .mem_ack_i(1'b0), .mem_data_i('0), .err_o(to_err), .grant_o(to_grant)
    );

    int tests = 0;
    int fails = 0;

    bit            pend [2];
    bit            m_wr [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    int            m_last;
    int            just_done;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive_port(input int p, input bit en, input bit wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        if (p == 0) begin r0_en = en; r0_wr = wr; r0_addr = a; r0_data = d; end
        else        begin r1_en = en; r1_wr = wr; r1_addr = a; r1_data = d; end
    endtask

    task automatic set_req(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[p] = 1'b1; m_wr[p] = wr; m_addr[p] = a; m_data[p] = d;
        drive_port(p, 1'b1, wr, a, d);
    endtask

    task automatic reset_model();
        pend[0] = 1'b0; pend[1] = 1'b0; m_last = 1; just_done = 2;
    endtask

    // Called at a post-edge point of an IDLE cycle; returns at a post-edge point of the following IDLE cycle.
    task automatic do_reset();
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        mem_ack = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        reset_model();
        @(posedge clk); #1;
    endtask

    // Predicts the winner, then runs one complete transaction with lat wait cycles before the ack.
    task automatic serve(input int lat, input bit refill, input logic [DW-1:0] rdata);
        int w;
        bit ewr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (pend[0] && pend[1]) w = 1 - m_last;
        else if (pend[0])       w = 0;
        else                    w = 1;
        ewr = m_wr[w]; ea = m_addr[w]; ed = m_data[w];
        @(posedge clk); #1;
        m_last = w;
        check("grant", grant, (w == 0) ? 2'b01 : 2'b10);
        check("mem_en", mem_en, 1'b1);
        check("mem_wr", mem_wr, ewr);
        check("mem_addr", mem_addr, ea);
        check("mem_data", mem_wdata, ed);
        if (refill && !pend[1-w]) set_req(1 - w, 1'($urandom_range(0, 1)), $urandom, rand_line());
        for (int c = 0; c < lat; c++) begin
            drive_port(w, 1'b1, !ewr, ea + 32'h20, ~ed);
            check("wait_ack0", ack0, 1'b0);
            check("wait_ack1", ack1, 1'b0);
            @(posedge clk); #1;
            check("hold_en", mem_en, 1'b1);
            check("hold_wr", mem_wr, ewr);
            check("hold_addr", mem_addr, ea);
            check("hold_data", mem_wdata, ed);
        end
        mem_ack = 1'b1; mem_rdata = rdata; #1;
        check("ack_w", (w == 0) ? ack0 : ack1, 1'b1);
        check("data_w", (w == 0) ? rd0 : rd1, rdata);
        check("ack_other", (w == 0) ? ack1 : ack0, 1'b0);
        check("data_other", (w == 0) ? rd1 : rd0, '0);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = rand_line();
        pend[w] = 1'b0; just_done = w;
        drive_port(w, 1'b0, 1'b0, '0, '0);
        check("dead_en", mem_en, 1'b0);
        check("dead_grant", grant, 2'b00);
        check("err_clear", err, 1'b0);
        mem_ack = 1'b1; #1;
        check("idle_ack0", ack0, 1'b0);
        check("idle_ack1", ack1, 1'b0);
        check("idle_rd0", rd0, '0);
        mem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rst_to_n = 1'b0; to_en = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        reset_model();
        #12;
        check("rst_en", mem_en, 1'b0);
        check("rst_wr", mem_wr, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_data", mem_wdata, '0);
        check("rst_err", err, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single port-0 read, enable high for cycles 1..10, ack in cycle 10 with data 5.
        set_req(0, 1'b0, 32'h0, '0);
        serve(9, 1'b0, 256'h5);

        // Simultaneous requests right after reset: port 0 first, then port 1.
        do_reset();
        set_req(0, 1'b1, 32'h20, 256'hA);
        set_req(1, 1'b0, 32'h400, '0);
        serve(2, 1'b0, rand_line());
        serve(3, 1'b0, rand_line());

        // Continuous contention, six transactions alternating 0,1,0,1,0,1.
        do_reset();
        set_req(0, 1'b0, $urandom, rand_line());
        set_req(1, 1'b1, $urandom, rand_line());
        for (int k = 0; k < 6; k++) serve(int'($urandom_range(0, 3)), 1'b1, rand_line());

        // Port 1 address moves 0x40 -> 0x60 mid-transaction; memory must keep 0x40.
        do_reset();
        set_req(1, 1'b0, 32'h40, rand_line());
        serve(3, 1'b0, rand_line());

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            if (!pend[0] && !pend[1]) begin
                if (just_done != 2 && $urandom_range(0, 2) == 0) begin
                    @(posedge clk); #1;
                    check("gap_en", mem_en, 1'b0);
                    just_done = 2;
                end
                if (just_done == 2) begin
                    int mask;
                    mask = int'($urandom_range(1, 3));
                    if (mask[0]) set_req(0, 1'($urandom_range(0, 1)), $urandom, rand_line());
                    if (mask[1]) set_req(1, 1'($urandom_range(0, 1)), $urandom, rand_line());
                end else begin
                    set_req(1 - just_done, 1'($urandom_range(0, 1)), $urandom, rand_line());
                end
            end
            serve(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), rand_line());
        end

        // Watchdog: TIMEOUT=8 instance with no memory ack.
        do_reset();
        rst_to_n = 1'b1;
        to_en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            check("to_busy_en", to_mem_en, 1'b1);
            check("to_busy_err", to_err, 1'b0);
            check("to_busy_ack", to_ack0, 1'b0);
        end
        @(posedge clk); #1;
        check("to_abort_en", to_mem_en, 1'b0);
        check("to_abort_err", to_err, 1'b1);
        check("to_abort_grant", to_grant, 2'b00);
        check("to_abort_ack", to_ack0, 1'b0);
        to_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("to_err_sticky", to_err, 1'b1);
        check("to_idle_en", to_mem_en, 1'b0);

        // Reset three cycles into a BUSY0 transaction, with a concurrent memory ack.
        set_req(0, 1'b1, 32'hDEAD_BEE0, rand_line());
        @(posedge clk); #1;
        check("pre_rst_en", mem_en, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0; mem_ack = 1'b1;
        #1;
        check("mid_rst_en", mem_en, 1'b0);
        check("mid_rst_wr", mem_wr, 1'b0);
        check("mid_rst_addr", mem_addr, '0);
        check("mid_rst_data", mem_wdata, '0);
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_ack0", ack0, 1'b0);
        check("mid_rst_rd0", rd0, '0);
        mem_ack = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
        set_req(0, 1'b0, 32'h100, rand_line());
        serve(2, 1'b0, rand_line());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
